dmem_pipe: RTL and testbench
============================

// Module: dmem_pipe
// PURPOSE
//  Parametrised, pipelined data memory for the MIPS core; successor to the single-cycle dmem.
//  Valid/ready request port with per-byte write enables and a configurable read latency.
//  In-order responses with backpressure, plus an error flag for misaligned or out-of-range accesses.
//  Sits between the core's load/store path and word-addressed storage.
// PARAMETERS
//  DATA_W   32  data width in bits; multiple of 8, power of two
//  DEPTH    64  number of DATA_W words; power of two
//  ADDR_W   32  byte-address width
//  LATENCY  1   acceptance-to-rsp_valid cycles; legal 1..4
// PORTS
//  clk        in   1         clock, rising edge
//  reset_n    in   1         asynchronous, active-low reset
//  req_valid  in   1         request present
//  req_ready  out  1         request accepted when req_valid && req_ready
//  req_we     in   1         1=write, 0=read
//  req_be     in   DATA_W/8  byte enables; used for writes only
//  req_addr   in   ADDR_W    byte address
//  req_wdata  in   DATA_W    write data
//  rsp_valid  out  1         response present
//  rsp_ready  in   1         response consumed when rsp_valid && rsp_ready
//  rsp_rdata  out  DATA_W    read data; 0 for writes and for errors
//  rsp_err    out  1         access was misaligned or out of range
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, all stage valids=0. Storage is not reset.
//  - Reset mid-operation drops every in-flight response. A write already committed stays committed.
//  - Stall = rsp_valid && !rsp_ready. req_ready = !stall (combinational). During a stall all stages hold.
//  - Word index: idx = req_addr >> log2(DATA_W/8).
//  - Misaligned: low log2(DATA_W/8) address bits != 0. Out of range: idx >= DEPTH.
//  - An erroring request writes nothing, and its response carries rsp_err=1 with rsp_rdata=0.
//  - Write: at the accepting edge, byte k is updated iff req_be[k].
//    - be=0 with we=1 is a legal no-op and still produces a response.
//  - Read: data is sampled at the accepting edge into stage 1.
//    - A read accepted the cycle after a write to the same word returns the new data.
//  - Every accepted request produces exactly one response, LATENCY cycles later plus stall cycles.
//  - Responses are in order. Throughput is 1 per cycle when no stall.
//  - Pipeline: LATENCY-deep shift register of {valid, err, rdata}; the last stage drives the rsp_* outputs.
//  - Simultaneous accept and response pop in the same cycle is legal and required for full throughput.
// CONFIGURATION
//  DMEM_STATS_EN defined: adds outputs rd_cnt, wr_cnt, err_cnt (16 bits each).
//    - Counted on request acceptance and saturating at 16'hFFFF.
//    - An erroring access increments err_cnt only.
//    - Cleared by reset_n.
//  DMEM_STATS_EN undefined: the ports and counters are absent; the datapath is identical.
// STRUCTURE
//  dmem_pkg:
//    - dmem_req_t and dmem_rsp_t structs
//    - BE_W = DATA_W/8 and OFS_W = $clog2(BE_W)
//    - function addr_err(addr, depth)
//  Sub-module dmem_array: byte-enable write, synchronous read, no reset. dmem_pipe holds the handshake, error check and stages.
// TESTING
//  1. Reset with reset_n=0 mid-burst (3 reads in flight) -> rsp_valid=0 next cycle; no stale responses after release.
//  2. Write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, LATENCY cycles after the read.
//  3. Write 0x000000AA to 0x10 with be=4'b0001, then read -> 0xDEADBEAA. be=0 write -> data unchanged.
//  4. Read 0x13 (misaligned) and read 0x100 (idx 64, DEPTH=64) -> rsp_err=1, rsp_rdata=0, memory untouched.
//  5. LATENCY=3, 8 back-to-back reads, rsp_ready held low 4 cycles -> req_ready low while stalled; all 8 returned in order, none lost or duplicated.
//  6. DMEM_STATS_EN: 3 reads, 2 writes, 1 error -> rd_cnt=3, wr_cnt=2, err_cnt=1; 70000 reads -> rd_cnt=16'hFFFF.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, default geometry and the address-legality check for the pipelined data memory.
// Optional statistics counters in dmem_pipe are enabled with `define DMEM_STATS_EN.
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DEPTH  = 64;

  localparam int BE_W  = DMEM_DATA_W / 8;
  localparam int OFS_W = $clog2(BE_W);

  typedef struct packed {
    logic                   we;
    logic [BE_W-1:0]        be;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic                   err;
    logic [DMEM_DATA_W-1:0] rdata;
  } dmem_rsp_t;

  // True when the byte address is not word aligned or its word index falls outside the array.
  function automatic logic addr_err(input logic [63:0] addr,
                                    input int unsigned depth,
                                    input int unsigned ofs_w = OFS_W);
    logic [63:0] mask;
    logic [63:0] idx;
    mask = (64'd1 << ofs_w) - 64'd1;
    idx  = addr >> ofs_w;
    return ((addr & mask) != 64'd0) || (idx >= 64'(depth));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with per-byte write enables and a registered read port.
// Storage has no reset; the read register only changes on an enabled read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic                       we,
  input  logic [DATA_W/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int k = 0; k < NBYTES; k++) begin
          if (be[k]) begin
            mem[idx][8*k +: 8] <= wdata[8*k +: 8];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined data memory: valid/ready request port, LATENCY-deep in-order response pipe with backpressure.
// Define DMEM_STATS_EN to add saturating rd_cnt/wr_cnt/err_cnt outputs.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]         rd_cnt,
  output logic [15:0]         wr_cnt,
  output logic [15:0]         err_cnt
`endif
);

  localparam int OFS_L = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);

  logic              stall;
  logic              accept;
  logic              req_err;
  logic              mem_en;
  logic [IDX_W-1:0]  widx;
  logic [DATA_W-1:0] arr_rdata;

  logic              s1_valid;
  logic              s1_err;
  logic              s1_rd;
  logic [DATA_W-1:0] s1_data;

  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = !stall;
  assign accept    = req_valid && req_ready;
  assign req_err   = addr_err(64'(req_addr), DEPTH, OFS_L);
  assign widx      = IDX_W'(req_addr >> OFS_L);
  assign mem_en    = accept && !req_err;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (req_we),
    .be    (req_be),
    .idx   (widx),
    .wdata (req_wdata),
    .rdata (arr_rdata)
  );

  // Stage 1 keeps only control bits; its data is the array's read register, which holds
  // through stalls because nothing can be accepted while the pipe is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_rd    <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      s1_err   <= accept && req_err;
      s1_rd    <= accept && !req_we && !req_err;
    end
  end

  assign s1_data = s1_rd ? arr_rdata : '0;

  generate
    if (LATENCY == 1) begin : g_lat1
      assign rsp_valid = s1_valid;
      assign rsp_err   = s1_err;
      assign rsp_rdata = s1_data;
    end else begin : g_latn
      logic [LATENCY-2:0] v_q;
      logic [LATENCY-2:0] e_q;
      logic [DATA_W-1:0]  d_q [LATENCY-1];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v_q <= '0;
          e_q <= '0;
          for (int i = 0; i < LATENCY - 1; i++) begin
            d_q[i] <= '0;
          end
        end else if (!stall) begin
          v_q[0] <= s1_valid;
          e_q[0] <= s1_err;
          d_q[0] <= s1_data;
          for (int i = 1; i < LATENCY - 1; i++) begin
            v_q[i] <= v_q[i-1];
            e_q[i] <= e_q[i-1];
            d_q[i] <= d_q[i-1];
          end
        end
      end

      assign rsp_valid = v_q[LATENCY-2];
      assign rsp_err   = e_q[LATENCY-2];
      assign rsp_rdata = d_q[LATENCY-2];
    end
  endgenerate

`ifdef DMEM_STATS_EN
  // An erroring access counts only as an error, never as a read or write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt  <= 16'd0;
      wr_cnt  <= 16'd0;
      err_cnt <= 16'd0;
    end else if (accept) begin
      if (req_err) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end else if (req_we) begin
        if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      end else begin
        if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_pipe.sv
// Self-checking bench for dmem_pipe (LATENCY=3): queue-based response model plus directed and random stimulus.
// Statistics checks are compiled in when DMEM_STATS_EN is defined.
module tb_dmem_pipe;
  import dmem_pkg::*;

  localparam int LAT   = 3;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  dmem_pipe #(
    .DATA_W  (32),
    .DEPTH   (DEPTH),
    .ADDR_W  (32),
    .LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
`ifdef DMEM_STATS_EN
    ,
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  typedef struct {
    dmem_rsp_t rsp;
    int        age;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;
  int          stall_seen = 0;
  int          m_rd = 0;
  int          m_wr = 0;
  int          m_err = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, got, want);
    end
  endtask

  // A response is due once its request has advanced LAT unstalled cycles.
  function automatic bit model_valid();
    return (exp_q.size() > 0) && (exp_q[0].age == LAT);
  endfunction

  function automatic int sat_inc(input int c);
    return (c < 65535) ? c + 1 : c;
  endfunction

  // Reference model: memory array, queue of expected responses and request counters.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        exp_q.delete();
        m_rd = 0;
        m_wr = 0;
        m_err = 0;
      end else begin : model_step
        bit          v;
        bit          stall;
        int unsigned a;
        exp_t        e;
        v = model_valid();
        stall = v && !rsp_ready;
        if (!stall) begin
          if (v) void'(exp_q.pop_front());
          for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            e.age++;
            exp_q[i] = e;
          end
          if (req_valid) begin
            a = req_addr;
            e.age = 1;
            e.rsp.err = 1'b0;
            e.rsp.rdata = 32'h0;
            if ((a % 4 != 0) || (a / 4 >= DEPTH)) begin
              e.rsp.err = 1'b1;
              m_err = sat_inc(m_err);
            end else if (req_we) begin
              for (int k = 0; k < 4; k++) begin
                if (req_be[k]) mem_m[a/4][8*k +: 8] = req_wdata[8*k +: 8];
              end
              m_wr = sat_inc(m_wr);
            end else begin
              e.rsp.rdata = mem_m[a/4];
              m_rd = sat_inc(m_rd);
            end
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  // Compare process: every negedge, outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset rsp_err", 32'(rsp_err), 32'h0);
`ifdef DMEM_STATS_EN
        checkOutput("reset rd_cnt", 32'(rd_cnt), 32'h0);
        checkOutput("reset err_cnt", 32'(err_cnt), 32'h0);
`endif
      end else begin : cmp_step
        bit v;
        v = model_valid();
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(v));
        checkOutput("req_ready", 32'(req_ready), 32'(!(v && !rsp_ready)));
        if (v) begin
          checkOutput("rsp_err", 32'(rsp_err), 32'(exp_q[0].rsp.err));
          checkOutput("rsp_rdata", rsp_rdata, exp_q[0].rsp.rdata);
        end
`ifdef DMEM_STATS_EN
        checkOutput("rd_cnt", 32'(rd_cnt), 32'(m_rd));
        checkOutput("wr_cnt", 32'(wr_cnt), 32'(m_wr));
        checkOutput("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
        if (rsp_valid && rsp_ready) hs_cnt++;
      end
    end
  end

  // Called at #1 after a posedge; drives one cycle and returns at #1 after the next posedge.
  task automatic applyStimulus(input logic v, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wd);
    req_valid = v;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Holds a request until accepted, bounded; counts cycles it saw req_ready low.
  task automatic sendReq(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wd;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready;
      if (!ok) stall_seen++;
      @(posedge clk);
      #1;
    end
    checkOutput("request accepted", 32'(ok), 32'h1);
  endtask

  task automatic readCheck(input string name, input logic [31:0] addr, input logic [31:0] want, input logic want_err);
    applyStimulus(1'b1, 1'b0, 4'h0, addr, 32'h0);
    idle(LAT - 1);
    checkOutput({name, " valid"}, 32'(rsp_valid), 32'h1);
    checkOutput({name, " rdata"}, rsp_rdata, want);
    checkOutput({name, " err"}, 32'(rsp_err), 32'(want_err));
  endtask

  initial begin : stim
    int h0;
    int unsigned sel;
    int unsigned addr;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("init rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("init rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("init rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("init req_ready", 32'(req_ready), 32'h1);
    reset_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b1, 4'hF, 32'(i * 4), (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5);
    end
    idle(LAT + 2);

    $display("[TB] full-word write and read back");
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    readCheck("t2 read 0x10", 32'h10, 32'hDEADBEEF, 1'b0);

    $display("[TB] byte-enable writes");
    applyStimulus(1'b1, 1'b1, 4'b0001, 32'h10, 32'h000000AA);
    readCheck("t3 be=1", 32'h10, 32'hDEADBEAA, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'b0000, 32'h10, 32'h12345678);
    readCheck("t3 be=0", 32'h10, 32'hDEADBEAA, 1'b0);

    $display("[TB] misaligned and out-of-range accesses");
    readCheck("t4 misaligned", 32'h13, 32'h0, 1'b1);
    readCheck("t4 out of range", 32'h100, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h100, 32'hFFFFFFFF);
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h12, 32'hFFFFFFFF);
    readCheck("t4 idx0 untouched", 32'h0, 32'hA5A5A5A5, 1'b0);
    readCheck("t4 0x10 untouched", 32'h10, 32'hDEADBEAA, 1'b0);

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    reset_n = 1'b0;
    req_valid = 1'b0;
    #1;
    checkOutput("t1 rsp_valid in reset", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    h0 = hs_cnt;
    idle(8);
    checkOutput("t1 stale responses", 32'(hs_cnt - h0), 32'h0);
    readCheck("t1 write survives reset", 32'h10, 32'hDEADBEAA, 1'b0);
    idle(2);

    $display("[TB] back-to-back reads with backpressure");
    h0 = hs_cnt;
    stall_seen = 0;
    fork
      begin
        repeat (LAT + 1) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 8; i++) sendReq(1'b0, 4'h0, 32'(i * 4), 32'h0);
    req_valid = 1'b0;
    for (int n = 0; n < 40 && (hs_cnt - h0) < 8; n++) idle(1);
    idle(3);
    checkOutput("t5 responses returned", 32'(hs_cnt - h0), 32'h8);
    checkOutput("t5 ready-low cycles", 32'(stall_seen), 32'h4);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 8) addr = $urandom_range(0, 7) * 4;
      else if (sel == 8) addr = $urandom_range(0, 7) * 4 + $urandom_range(1, 3);
      else addr = (DEPTH + $urandom_range(0, 100)) * 4;
      applyStimulus(($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), addr, $urandom);
    end
    rsp_ready = 1'b1;
    idle(LAT + 4);

`ifdef DMEM_STATS_EN
    $display("[TB] statistics counters");
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h20, 32'h01234567);
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h24, 32'h89ABCDEF);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h13, 32'h0);
    idle(LAT + 1);
    checkOutput("t6 rd_cnt", 32'(rd_cnt), 32'd3);
    checkOutput("t6 wr_cnt", 32'(wr_cnt), 32'd2);
    checkOutput("t6 err_cnt", 32'(err_cnt), 32'd1);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    repeat (70000) @(posedge clk);
    #1;
    req_valid = 1'b0;
    idle(LAT + 1);
    checkOutput("t6 rd_cnt saturated", 32'(rd_cnt), 32'h0000FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
